// File: rtl/sdes_round_scheduler.sv
// Shares one external combinational SDES fk unit between two requesters.
// Each accepted block runs IP, fk(ka), SW, fk(kb), IP^-1 and leaves on a valid/ready port.
module sdes_round_scheduler #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] key1_i,
   input  logic [7:0] key2_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [7:0] data0_i,
   input  logic [7:0] data1_i,
   input  logic       decrypt0_i,
   input  logic       decrypt1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic [7:0] fk_in_o,
   output logic [7:0] fk_key_o,
   input  logic [7:0] fk_out_i,
   output logic       res_valid_o,
   output logic [7:0] res_data_o,
   output logic       res_id_o,
   input  logic       res_ready_i,
   output logic       busy_o
);

   typedef enum logic [1:0] {StIdle, StR1, StR2, StOut} state_e;

   state_e     state_q, state_d;
   logic [7:0] blk_q, blk_d;
   logic [7:0] ka_q, ka_d;
   logic [7:0] kb_q, kb_d;
   logic       id_q, id_d;
   logic       last_q, last_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] res_data_q, res_data_d;
   logic       res_id_q, res_id_d;

   logic       pick;
   logic [7:0] pick_data;
   logic       pick_dec;

   // SDES position 1 is bit 7.
   function automatic logic [7:0] ip(input logic [7:0] v);
      return {v[6], v[2], v[5], v[7], v[4], v[0], v[3], v[1]};
   endfunction

   function automatic logic [7:0] ip_inv(input logic [7:0] v);
      return {v[4], v[7], v[5], v[3], v[1], v[6], v[0], v[2]};
   endfunction

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      ka_d        = ka_q;
      kb_d        = kb_q;
      id_d        = id_q;
      last_d      = last_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      fk_in_o     = 8'h00;
      fk_key_o    = 8'h00;
      pick        = 1'b0;
      pick_data   = 8'h00;
      pick_dec    = 1'b0;
      case (state_q)
         StIdle: begin
            if (req0_i || req1_i) begin
               // On a tie the channel that did not win last time goes next.
               if (req0_i && req1_i) begin
                  pick = FIXED_PRIO ? 1'b0 : ~last_q;
               end else begin
                  pick = req1_i;
               end
               pick_data = pick ? data1_i : data0_i;
               pick_dec  = pick ? decrypt1_i : decrypt0_i;
               blk_d     = ip(pick_data);
               ka_d      = pick_dec ? key2_i : key1_i;
               kb_d      = pick_dec ? key1_i : key2_i;
               id_d      = pick;
               last_d    = pick;
               gnt0_d    = ~pick;
               gnt1_d    = pick;
               state_d   = StR1;
            end
         end
         StR1: begin
            fk_in_o  = blk_q;
            fk_key_o = ka_q;
            blk_d    = {fk_out_i[3:0], fk_out_i[7:4]};
            state_d  = StR2;
         end
         StR2: begin
            fk_in_o     = blk_q;
            fk_key_o    = kb_q;
            res_data_d  = ip_inv(fk_out_i);
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = StOut;
         end
         StOut: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         blk_q       <= 8'h00;
         ka_q        <= 8'h00;
         kb_q        <= 8'h00;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         ka_q        <= ka_d;
         kb_q        <= kb_d;
         id_q        <= id_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
      end
   end

   assign gnt0_o      = gnt0_q;
   assign gnt1_o      = gnt1_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_id_o    = res_id_q;
   assign busy_o      = (state_q != StIdle);

endmodule
